// File: rtl/tm1638_source_arbiter_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tm1638_source_arbiter_if : source-side and driver-side bundle for the    |
// |                            TM1638 frame-source arbiter                   |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
interface tm1638_source_arbiter_if #(
  parameter int NUM_SRC = 8,
  parameter int SEG_W   = 64,
  parameter int LED_W   = 8,
  parameter int SEL_W   = $clog2(NUM_SRC)
);
  logic                     i_Next;
  logic [NUM_SRC*SEG_W-1:0] i_Segments;
  logic [NUM_SRC*LED_W-1:0] i_Leds;
  logic [NUM_SRC-1:0]       i_Valid;
  logic                     i_Drv_Busy;
  logic [SEG_W-1:0]         o_Segments;
  logic [LED_W-1:0]         o_Leds;
  logic                     o_Valid;
  logic [SEL_W-1:0]         o_Sel;
  logic [15:0]              o_Overwrites;

  // master: frame sources plus driver status; slave: the arbiter itself
  modport master (
    output i_Next, i_Segments, i_Leds, i_Valid, i_Drv_Busy,
    input  o_Segments, o_Leds, o_Valid, o_Sel, o_Overwrites
  );

  modport slave (
    input  i_Next, i_Segments, i_Leds, i_Valid, i_Drv_Busy,
    output o_Segments, o_Leds, o_Valid, o_Sel, o_Overwrites
  );
endinterface
`default_nettype wire

// File: rtl/tm1638_source_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tm1638_source_arbiter : buffers NUM_SRC frame sources and feeds the      |
// |   selected one to tm1638_driver when idle. Optional diagnostics via      |
// |   macro TM1638_SOURCE_ARBITER_DIAG_EN.                                   |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tm1638_source_arbiter #(
  parameter int NUM_SRC     = 8,
  parameter int SEG_W       = 64,
  parameter int LED_W       = 8,
  parameter int AUTO_CYCLES = 0,
  parameter int SEL_W       = $clog2(NUM_SRC)
) (
  input  logic                   i_Clk,
  input  logic                   i_Rst,
`ifdef TM1638_SOURCE_ARBITER_DIAG_EN
  output logic [1:0]             o_Diag_State,
  output logic [NUM_SRC-1:0]     o_Diag_Pending,
  output logic [NUM_SRC-1:0]     o_Diag_Loaded,
`endif
  tm1638_source_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    GUARD = 2'd2,
    DRAIN = 2'd3
  } state_t;

  localparam int               DWELL_W      = (AUTO_CYCLES > 1) ? $clog2(AUTO_CYCLES) : 1;
  localparam logic [SEL_W-1:0] C_LAST_SEL   = SEL_W'(NUM_SRC - 1);
  localparam logic [DWELL_W-1:0] C_DWELL_LAST = DWELL_W'(AUTO_CYCLES - 1);

  state_t             state_q, state_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic [NUM_SRC-1:0] loaded_q, loaded_d;
  logic [SEG_W-1:0]   seg_buf_q [NUM_SRC];
  logic [SEG_W-1:0]   seg_buf_d [NUM_SRC];
  logic [LED_W-1:0]   led_buf_q [NUM_SRC];
  logic [LED_W-1:0]   led_buf_d [NUM_SRC];
  logic [SEG_W-1:0]   out_seg_q, out_seg_d;
  logic [LED_W-1:0]   out_led_q, out_led_d;
  logic               valid_q, valid_d;
  logic [15:0]        ovw_q, ovw_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;

  logic               auto_adv;
  logic               advance;
  logic [SEL_W-1:0]   sel_inc;

  // Selection and dwell timer; auto and manual advances collapse into one step.
  always_comb begin
    sel_inc  = (sel_q == C_LAST_SEL) ? '0 : sel_q + SEL_W'(1);
    auto_adv = 1'b0;
    dwell_d  = dwell_q;
    if (AUTO_CYCLES > 0) begin
      auto_adv = (dwell_q == C_DWELL_LAST);
      if (bus.i_Next || auto_adv) begin
        dwell_d = '0;
      end else begin
        dwell_d = dwell_q + DWELL_W'(1);
      end
    end
    advance = bus.i_Next | auto_adv;
    sel_d   = advance ? sel_inc : sel_q;
  end

  // Capture, pending bookkeeping and overwrite counting.
  always_comb begin
    seg_buf_d = seg_buf_q;
    led_buf_d = led_buf_q;
    loaded_d  = loaded_q;
    pending_d = pending_q;
    ovw_d     = ovw_q;

    // Order matters: issue clear first, so switch and capture sets win.
    if (state_q == ISSUE) begin
      pending_d[sel_q] = 1'b0;
    end
    if (advance) begin
      pending_d[sel_inc] = 1'b1;
    end
    for (int k = 0; k < NUM_SRC; k++) begin
      if (bus.i_Valid[k]) begin
        seg_buf_d[k] = bus.i_Segments[k*SEG_W +: SEG_W];
        led_buf_d[k] = bus.i_Leds[k*LED_W +: LED_W];
        pending_d[k] = 1'b1;
        loaded_d[k]  = 1'b1;
      end
    end

    if (bus.i_Valid[sel_q] && pending_q[sel_q] && (state_q != ISSUE) &&
        (ovw_q != 16'hFFFF)) begin
      ovw_d = ovw_q + 16'd1;
    end
  end

  // Issue FSM; outputs are registered so they align with the ISSUE state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pending_q[sel_q] && !bus.i_Drv_Busy) state_d = ISSUE;
      ISSUE:   state_d = GUARD;
      GUARD:   state_d = DRAIN;
      DRAIN:   if (!bus.i_Drv_Busy) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    valid_d   = (state_d == ISSUE);
    out_seg_d = out_seg_q;
    out_led_d = out_led_q;
    if (state_d == ISSUE) begin
      out_seg_d = loaded_d[sel_d] ? seg_buf_d[sel_d] : '0;
      out_led_d = loaded_d[sel_d] ? led_buf_d[sel_d] : '0;
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q   <= IDLE;
      sel_q     <= '0;
      pending_q <= '0;
      loaded_q  <= '0;
      seg_buf_q <= '{default: '0};
      led_buf_q <= '{default: '0};
      out_seg_q <= '0;
      out_led_q <= '0;
      valid_q   <= 1'b0;
      ovw_q     <= '0;
      dwell_q   <= '0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      pending_q <= pending_d;
      loaded_q  <= loaded_d;
      seg_buf_q <= seg_buf_d;
      led_buf_q <= led_buf_d;
      out_seg_q <= out_seg_d;
      out_led_q <= out_led_d;
      valid_q   <= valid_d;
      ovw_q     <= ovw_d;
      dwell_q   <= dwell_d;
    end
  end

  assign bus.o_Segments   = out_seg_q;
  assign bus.o_Leds       = out_led_q;
  assign bus.o_Valid      = valid_q;
  assign bus.o_Sel        = sel_q;
  assign bus.o_Overwrites = ovw_q;

`ifdef TM1638_SOURCE_ARBITER_DIAG_EN
  assign o_Diag_State   = state_q;
  assign o_Diag_Pending = pending_q;
  assign o_Diag_Loaded  = loaded_q;
`else
  // Diagnostics compiled out; the state, pending and loaded registers stay internal.
`endif

endmodule
`default_nettype wire

// File: tb/tb_tm1638_source_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_tm1638_source_arbiter : directed vector table plus auto-rotate run    |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tb_tm1638_source_arbiter;

  logic clk = 1'b0;
  logic rst;
  logic rst2;

  always #5 clk = ~clk;

  tm1638_source_arbiter_if #(.NUM_SRC(8), .SEG_W(64), .LED_W(8)) bus ();
  tm1638_source_arbiter_if #(.NUM_SRC(4), .SEG_W(64), .LED_W(8)) bus2 ();

  tm1638_source_arbiter #(
    .NUM_SRC(8), .SEG_W(64), .LED_W(8), .AUTO_CYCLES(0)
  ) dut (
    .i_Clk (clk),
    .i_Rst (rst),
    .bus   (bus)
  );

  tm1638_source_arbiter #(
    .NUM_SRC(4), .SEG_W(64), .LED_W(8), .AUTO_CYCLES(10)
  ) dut_auto (
    .i_Clk (clk),
    .i_Rst (rst2),
    .bus   (bus2)
  );

  typedef struct {
    logic        rst;
    logic        nxt;
    int          vsrc;
    logic [63:0] seg;
    logic [7:0]  led;
    logic        busy;
    logic        e_valid;
    logic [63:0] e_seg;
    logic [7:0]  e_led;
    logic [2:0]  e_sel;
    logic [15:0] e_ovw;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic n, input int vs, input logic [63:0] s,
                     input logic [7:0] l, input logic b, input logic ev,
                     input logic [63:0] es, input logic [7:0] el, input logic [2:0] esl,
                     input logic [15:0] eo);
    vec_t v;
    v = '{r, n, vs, s, l, b, ev, es, el, esl, eo};
    vecs.push_back(v);
  endtask

  initial begin
    int exp_sel;
    rst = 1'b1;
    rst2 = 1'b1;
    bus.i_Next = 1'b0; bus.i_Segments = '0; bus.i_Leds = '0;
    bus.i_Valid = '0; bus.i_Drv_Busy = 1'b0;
    bus2.i_Next = 1'b0; bus2.i_Segments = '0; bus2.i_Leds = '0;
    bus2.i_Valid = '0; bus2.i_Drv_Busy = 1'b0;

    //  rst nxt src seg    led   busy | valid seg    led   sel ovw
    add(1, 0, -1, 0,     0,    0,     0, 0,     0,    0, 0);
    add(1, 0, -1, 0,     0,    0,     0, 0,     0,    0, 0);
    add(0, 0,  0, 'h3F,  'h80, 0,     0, 0,     0,    0, 0);
    add(0, 0, -1, 0,     0,    0,     1, 'h3F,  'h80, 0, 0);
    add(0, 0, -1, 0,     0,    0,     0, 'h3F,  'h80, 0, 0);
    add(0, 0, -1, 0,     0,    1,     0, 'h3F,  'h80, 0, 0);
    add(0, 0, -1, 0,     0,    1,     0, 'h3F,  'h80, 0, 0);
    add(0, 0, -1, 0,     0,    0,     0, 'h3F,  'h80, 0, 0);
    // switch to never-loaded source 1: blank frame
    add(0, 1, -1, 0,     0,    0,     0, 'h3F,  'h80, 1, 0);
    add(0, 0, -1, 0,     0,    0,     1, 0,     0,    1, 0);
    add(0, 0, -1, 0,     0,    0,     0, 0,     0,    1, 0);
    add(0, 0, -1, 0,     0,    0,     0, 0,     0,    1, 0);
    add(0, 0, -1, 0,     0,    0,     0, 0,     0,    1, 0);
    add(0, 0,  1, 'h06,  'h01, 0,     0, 0,     0,    1, 0);
    add(0, 0, -1, 0,     0,    0,     1, 'h06,  'h01, 1, 0);
    add(0, 0, -1, 0,     0,    0,     0, 'h06,  'h01, 1, 0);
    add(0, 0, -1, 0,     0,    0,     0, 'h06,  'h01, 1, 0);
    add(0, 0, -1, 0,     0,    0,     0, 'h06,  'h01, 1, 0);
    // busy held: three frames, two overwrites
    add(0, 0,  1, 'h11,  'h11, 1,     0, 'h06,  'h01, 1, 0);
    add(0, 0,  1, 'h22,  'h22, 1,     0, 'h06,  'h01, 1, 1);
    add(0, 0,  1, 'h33,  'h33, 1,     0, 'h06,  'h01, 1, 2);
    add(0, 0, -1, 0,     0,    1,     0, 'h06,  'h01, 1, 2);
    add(0, 0, -1, 0,     0,    0,     1, 'h33,  'h33, 1, 2);
    add(0, 0, -1, 0,     0,    0,     0, 'h33,  'h33, 1, 2);
    add(0, 0, -1, 0,     0,    0,     0, 'h33,  'h33, 1, 2);
    add(0, 0, -1, 0,     0,    0,     0, 'h33,  'h33, 1, 2);
    add(0, 0, -1, 0,     0,    0,     0, 'h33,  'h33, 1, 2);
    // walk selection to 7 with busy high, then wrap to 0
    for (int s = 2; s <= 7; s++) add(0, 1, -1, 0, 0, 1, 0, 'h33, 'h33, 3'(s), 2);
    add(0, 1, -1, 0,     0,    1,     0, 'h33,  'h33, 0, 2);
    add(0, 0, -1, 0,     0,    0,     1, 'h3F,  'h80, 0, 2);
    add(0, 0, -1, 0,     0,    0,     0, 'h3F,  'h80, 0, 2);
    add(0, 0, -1, 0,     0,    1,     0, 'h3F,  'h80, 0, 2);
    // switch during DRAIN
    add(0, 1, -1, 0,     0,    1,     0, 'h3F,  'h80, 1, 2);
    add(0, 0, -1, 0,     0,    1,     0, 'h3F,  'h80, 1, 2);
    add(0, 0, -1, 0,     0,    0,     0, 'h3F,  'h80, 1, 2);
    add(0, 0, -1, 0,     0,    0,     1, 'h33,  'h33, 1, 2);
    add(0, 0, -1, 0,     0,    0,     0, 'h33,  'h33, 1, 2);
    add(0, 0, -1, 0,     0,    0,     0, 'h33,  'h33, 1, 2);
    add(0, 0, -1, 0,     0,    0,     0, 'h33,  'h33, 1, 2);
    // capture during ISSUE: set wins, not an overwrite
    add(0, 0,  1, 'h44,  'h44, 0,     0, 'h33,  'h33, 1, 2);
    add(0, 0, -1, 0,     0,    0,     1, 'h44,  'h44, 1, 2);
    add(0, 0,  1, 'h55,  'h55, 0,     0, 'h44,  'h44, 1, 2);
    add(0, 0, -1, 0,     0,    0,     0, 'h44,  'h44, 1, 2);
    add(0, 0, -1, 0,     0,    0,     0, 'h44,  'h44, 1, 2);
    add(0, 0, -1, 0,     0,    0,     1, 'h55,  'h55, 1, 2);
    add(0, 0, -1, 0,     0,    0,     0, 'h55,  'h55, 1, 2);
    add(0, 0, -1, 0,     0,    0,     0, 'h55,  'h55, 1, 2);
    add(0, 0, -1, 0,     0,    0,     0, 'h55,  'h55, 1, 2);
    // switch in the ISSUE cycle, then capture on new source during GUARD
    add(0, 0,  1, 'h77,  'h77, 0,     0, 'h55,  'h55, 1, 2);
    add(0, 0, -1, 0,     0,    0,     1, 'h77,  'h77, 1, 2);
    add(0, 1, -1, 0,     0,    0,     0, 'h77,  'h77, 2, 2);
    add(0, 0,  2, 'h66,  'h66, 0,     0, 'h77,  'h77, 2, 3);
    add(0, 0, -1, 0,     0,    0,     0, 'h77,  'h77, 2, 3);
    add(0, 0, -1, 0,     0,    0,     1, 'h66,  'h66, 2, 3);
    add(0, 0, -1, 0,     0,    1,     0, 'h66,  'h66, 2, 3);
    add(0, 0, -1, 0,     0,    1,     0, 'h66,  'h66, 2, 3);
    add(0, 0,  2, 'h99,  'h99, 1,     0, 'h66,  'h66, 2, 3);
    // reset in DRAIN with source 2 pending
    add(1, 0, -1, 0,     0,    1,     0, 0,     0,    0, 0);
    add(0, 0, -1, 0,     0,    0,     0, 0,     0,    0, 0);
    add(0, 0, -1, 0,     0,    0,     0, 0,     0,    0, 0);
    add(0, 0,  0, 'hAA,  'h0A, 0,     0, 0,     0,    0, 0);
    add(0, 0, -1, 0,     0,    0,     1, 'hAA,  'h0A, 0, 0);

    foreach (vecs[i]) begin
      rst            = vecs[i].rst;
      bus.i_Next     = vecs[i].nxt;
      bus.i_Drv_Busy = vecs[i].busy;
      bus.i_Valid    = '0;
      bus.i_Segments = '0;
      bus.i_Leds     = '0;
      if (vecs[i].vsrc >= 0) begin
        bus.i_Valid[vecs[i].vsrc]                 = 1'b1;
        bus.i_Segments[vecs[i].vsrc*64 +: 64]     = vecs[i].seg;
        bus.i_Leds[vecs[i].vsrc*8 +: 8]           = vecs[i].led;
      end
      @(posedge clk);
      #1;
      chk($sformatf("v%0d o_Valid", i),      64'(bus.o_Valid),      64'(vecs[i].e_valid));
      chk($sformatf("v%0d o_Segments", i),   bus.o_Segments,        vecs[i].e_seg);
      chk($sformatf("v%0d o_Leds", i),       64'(bus.o_Leds),       64'(vecs[i].e_led));
      chk($sformatf("v%0d o_Sel", i),        64'(bus.o_Sel),        64'(vecs[i].e_sel));
      chk($sformatf("v%0d o_Overwrites", i), 64'(bus.o_Overwrites), 64'(vecs[i].e_ovw));
    end
    rst = 1'b0;
    bus.i_Next = 1'b0;
    bus.i_Valid = '0;

    // Auto-rotate: dwell 10, manual pulse at cycle 15, coincident pulse at 35
    @(posedge clk);
    #1;
    chk("auto reset o_Sel", 64'(bus2.o_Sel), 64'd0);
    rst2 = 1'b0;
    for (int n = 1; n <= 45; n++) begin
      bus2.i_Next = (n == 15) || (n == 35);
      @(posedge clk);
      #1;
      if (n < 10)      exp_sel = 0;
      else if (n < 15) exp_sel = 1;
      else if (n < 25) exp_sel = 2;
      else if (n < 35) exp_sel = 3;
      else if (n < 45) exp_sel = 0;
      else             exp_sel = 1;
      chk($sformatf("auto n%0d o_Sel", n), 64'(bus2.o_Sel), 64'(exp_sel));
    end
    bus2.i_Next = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
